ram_arbiter: RTL and testbench

//  Shares one single-port ram instance between the core's instruction-fetch port (A, read-only)
//  and its load/store port (B, read/write). Grants at most one access per clock and drives the
//  RAM address, write data and write enable. Returns read data one cycle later. Prevents

---
 rtl/ram_arbiter_if.sv | 50 +++++
 rtl/ram_arbiter.sv | 112 +++++++++++
 tb/tb_ram_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - bundle of fetch, load/store and ram-side signals for ram_arbiter
//
// Signals:
//   a_req/a_addr -> a_gnt/a_rvalid/a_rdata                    fetch port (read-only)
//   b_req/b_we/b_addr/b_wdata -> b_gnt/b_rvalid/b_rdata       load/store port
//   ram_addr/ram_wdata/ram_we -> ram, ram_rdata <- ram        single-port ram side
// Modports:
//   slave  : the arbiter
//   master : the environment (core ports plus the ram block)
interface ram_arbiter_if #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 8
);
  logic               a_req;
  logic [ADDR_SZ-1:0] a_addr;
  logic               a_gnt;
  logic               a_rvalid;
  logic [DATA_SZ-1:0] a_rdata;

  logic               b_req;
  logic               b_we;
  logic [ADDR_SZ-1:0] b_addr;
  logic [DATA_SZ-1:0] b_wdata;
  logic               b_gnt;
  logic               b_rvalid;
  logic [DATA_SZ-1:0] b_rdata;

  logic [ADDR_SZ-1:0] ram_addr;
  logic [DATA_SZ-1:0] ram_wdata;
  logic               ram_we;
  logic [DATA_SZ-1:0] ram_rdata;

  modport slave (
    input  a_req, a_addr,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata
  );

  modport master (
    output a_req, a_addr,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-port ram between a fetch port (A) and a load/store port (B)
//
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous reset, active-high
//   bus  ram_arbiter_if.slave
//          A: a_req, a_addr in; a_gnt, a_rvalid, a_rdata out
//          B: b_req, b_we, b_addr, b_wdata in; b_gnt, b_rvalid, b_rdata out
//          ram: ram_addr, ram_wdata, ram_we out; ram_rdata in
// Parameters:
//   ADDR_SZ, DATA_SZ  widths, matching the ram
//   MAX_B_BURST       max consecutive B grants while A waits (1..15)
module ram_arbiter #(
  parameter int ADDR_SZ     = 8,
  parameter int DATA_SZ     = 8,
  parameter int MAX_B_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_B_BURST);

  logic [3:0]         burst_cnt;
  logic [ADDR_SZ-1:0] last_addr_q;
  logic               resp_pend_q;
  logic               resp_is_b_q;
  logic               a_rvalid_q;
  logic               b_rvalid_q;
  logic [DATA_SZ-1:0] a_rdata_q;
  logic [DATA_SZ-1:0] b_rdata_q;

  logic               a_gnt_c;
  logic               b_gnt_c;
  logic [ADDR_SZ-1:0] ram_addr_c;

  // Grants are gated by rst so nothing reaches the ram while reset is held,
  // even with requests asserted.
  always_comb begin
    a_gnt_c = 1'b0;
    b_gnt_c = 1'b0;
    if (!rst) begin
      if (bus.b_req && (!bus.a_req || burst_cnt < MAX_CNT)) begin
        b_gnt_c = 1'b1;
      end else if (bus.a_req) begin
        a_gnt_c = 1'b1;
      end
    end
  end

  // With no grant the ram keeps seeing the last granted address.
  always_comb begin
    ram_addr_c = last_addr_q;
    if (a_gnt_c) begin
      ram_addr_c = bus.a_addr;
    end else if (b_gnt_c) begin
      ram_addr_c = bus.b_addr;
    end
  end

  assign bus.a_gnt     = a_gnt_c;
  assign bus.b_gnt     = b_gnt_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_we    = b_gnt_c & bus.b_we;
  assign bus.ram_wdata = rst ? '0 : bus.b_wdata;
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.b_rvalid  = b_rvalid_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt   <= '0;
      last_addr_q <= '0;
      resp_pend_q <= 1'b0;
      resp_is_b_q <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      // Count B grants only while A is actually waiting; any A grant or an
      // idle A port restarts the budget.
      if (a_gnt_c || !bus.a_req) begin
        burst_cnt <= '0;
      end else if (b_gnt_c && burst_cnt < MAX_CNT) begin
        burst_cnt <= burst_cnt + 4'd1;
      end

      if (a_gnt_c || b_gnt_c) begin
        last_addr_q <= ram_addr_c;
      end

      // Read grant at this edge: ram data appears after it and is captured
      // at the next edge, which is when the owning port's rvalid rises.
      resp_pend_q <= a_gnt_c || (b_gnt_c && !bus.b_we);
      resp_is_b_q <= b_gnt_c;

      a_rvalid_q <= resp_pend_q && !resp_is_b_q;
      b_rvalid_q <= resp_pend_q && resp_is_b_q;

      if (resp_pend_q && !resp_is_b_q) begin
        a_rdata_q <= bus.ram_rdata;
      end
      if (resp_pend_q && resp_is_b_q) begin
        b_rdata_q <= bus.ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural ram and reference memory
module tb_ram_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_SZ(AW), .DATA_SZ(DW)) bus ();

  ram_arbiter #(.ADDR_SZ(AW), .DATA_SZ(DW), .MAX_B_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port ram: write and read sampled at the same edge.
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ram_q;
  bit            ram_init = 1'b0;
  assign bus.ram_rdata = ram_q;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i * 37 + 11);
      ram_init <= 1'b1;
    end else begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      ram_q <= ram_mem[bus.ram_addr];
    end
  end

  // Scoreboard / reference model
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] ref_mem [256];
  bit            ref_init = 1'b0;
  int            cyc = 0;
  int            waiting_b = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] a_hold = '0;
  logic [DW-1:0] b_hold = '0;
  int            n_vec = 0;
  int            n_err = 0;
  bit            done = 1'b0;
  bit            drained_checked = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    bit   exp_a, exp_b, rv_a, rv_b;
    exp_t e;
    cyc++;
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
      ref_init = 1'b1;
    end
    if (rst) begin
      chk("rst_ctrl", 32'({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.ram_we}), 32'd0);
      chk("rst_rdata", 32'({bus.a_rdata, bus.b_rdata}), 32'd0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
      qa.delete();
      qb.delete();
      waiting_b = 0;
      last_addr = '0;
      a_hold    = '0;
      b_hold    = '0;
    end else begin
      // Responses: each read comes back exactly two sampling points after its grant.
      rv_a = (qa.size() > 0) && (cyc - qa[0].cyc == 2);
      rv_b = (qb.size() > 0) && (cyc - qb[0].cyc == 2);
      chk("a_rvalid", 32'(bus.a_rvalid), 32'(rv_a));
      chk("b_rvalid", 32'(bus.b_rvalid), 32'(rv_b));
      chk("single_rvalid", 32'(bus.a_rvalid & bus.b_rvalid), 32'd0);
      if (rv_a) begin
        e = qa.pop_front();
        if (bus.a_rvalid) chk("a_rdata", 32'(bus.a_rdata), 32'(e.data));
        a_hold = e.data;
      end else begin
        chk("a_rdata_hold", 32'(bus.a_rdata), 32'(a_hold));
      end
      if (rv_b) begin
        e = qb.pop_front();
        if (bus.b_rvalid) chk("b_rdata", 32'(bus.b_rdata), 32'(e.data));
        b_hold = e.data;
      end else begin
        chk("b_rdata_hold", 32'(bus.b_rdata), 32'(b_hold));
      end

      // Grants: B wins contention until it has taken MAXB grants in a row while A waited.
      exp_a = bus.a_req && (!bus.b_req || waiting_b >= MAXB);
      exp_b = bus.b_req && !exp_a;
      chk("a_gnt", 32'(bus.a_gnt), 32'(exp_a));
      chk("b_gnt", 32'(bus.b_gnt), 32'(exp_b));
      chk("ram_we", 32'(bus.ram_we), 32'(exp_b && bus.b_we));

      if (exp_a) begin
        chk("ram_addr_a", 32'(bus.ram_addr), 32'(bus.a_addr));
        last_addr = bus.a_addr;
        qa.push_back('{data: ref_mem[bus.a_addr], cyc: cyc});
      end else if (exp_b) begin
        chk("ram_addr_b", 32'(bus.ram_addr), 32'(bus.b_addr));
        last_addr = bus.b_addr;
        if (bus.b_we) begin
          chk("ram_wdata", 32'(bus.ram_wdata), 32'(bus.b_wdata));
          ref_mem[bus.b_addr] = bus.b_wdata;
        end else begin
          qb.push_back('{data: ref_mem[bus.b_addr], cyc: cyc});
        end
      end else begin
        chk("ram_addr_idle", 32'(bus.ram_addr), 32'(last_addr));
      end

      if (exp_a || !bus.a_req) waiting_b = 0;
      else if (exp_b && waiting_b < MAXB) waiting_b++;
    end

    if (done && !drained_checked) begin
      chk("qa_drained", 32'(qa.size()), 32'd0);
      chk("qb_drained", 32'(qb.size()), 32'd0);
      drained_checked = 1'b1;
    end
  end

  // Stimulus
  bit seen_a, seen_b;

  task automatic tick();
    @(negedge clk);
    seen_a = bus.a_gnt;
    seen_b = bus.b_gnt;
    @(posedge clk);
    #1;
  endtask

  // Hold outstanding requests until granted, then drop them (bounded).
  task automatic drain();
    for (int i = 0; i < 40 && (bus.a_req || bus.b_req); i++) begin
      tick();
      if (seen_a) bus.a_req = 1'b0;
      if (seen_b) bus.b_req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic contend(input int n);
    bus.a_req = 1'b1;
    bus.b_req = 1'b1;
    repeat (n) begin
      tick();
      if (seen_a) bus.a_addr = 8'($urandom);
      if (seen_b) begin
        bus.b_we    = 1'($urandom);
        bus.b_addr  = 8'($urandom);
        bus.b_wdata = 8'($urandom);
      end
    end
    drain();
  endtask

  initial begin
    rst         = 1'b1;
    bus.a_req   = 1'b1;
    bus.a_addr  = 8'h40;
    bus.b_req   = 1'b1;
    bus.b_we    = 1'b0;
    bus.b_addr  = 8'h41;
    bus.b_wdata = 8'h00;
    seen_a      = 1'b0;
    seen_b      = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Both ports saturated: B,B,B,B,A pattern, first grant B.
    contend(20);
    idle(3);

    // Back-to-back fetches from 0x10.
    bus.a_req  = 1'b1;
    bus.a_addr = 8'h10;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (seen_a) bus.a_addr = 8'(8'h10 + i);
    end
    drain();
    idle(3);

    // Store then load at 0x20.
    bus.b_req   = 1'b1;
    bus.b_we    = 1'b1;
    bus.b_addr  = 8'h20;
    bus.b_wdata = 8'hA5;
    drain();
    bus.b_req = 1'b1;
    bus.b_we  = 1'b0;
    drain();
    idle(3);

    // Reset one cycle after an A read grant drops the response.
    bus.a_req  = 1'b1;
    bus.a_addr = 8'h33;
    drain();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    idle(3);
    contend(12);
    idle(3);

    // Random traffic on a small address window to provoke read-after-write.
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (!bus.a_req || seen_a) begin
        bus.a_req  = ($urandom % 4) != 0;
        bus.a_addr = 8'($urandom_range(0, 15));
      end
      if (!bus.b_req || seen_b) begin
        bus.b_req   = ($urandom % 4) != 0;
        bus.b_we    = 1'($urandom);
        bus.b_addr  = 8'($urandom_range(0, 15));
        bus.b_wdata = 8'($urandom);
      end
    end
    drain();
    idle(5);
    done = 1'b1;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
